// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and helpers for the instruction fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [2:0] {
        S_BOOT_REQ  = 3'd0,
        S_BOOT_WAIT = 3'd1,
        S_FETCH     = 3'd2,
        S_WAIT      = 3'd3,
        S_FAULT     = 3'd4
    } fetch_state_e;

    localparam logic [2:0] MEM_SIZE_WORD = 3'b010;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ibuf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ibuf
// Description : Show-ahead FIFO of {pc, instruction} with synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ibuf #(
    parameter int IBUF_DEPTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [ADDR_WIDTH-1:0]        push_pc_i,
    input  logic [DATA_WIDTH-1:0]        push_data_i,
    input  logic                         pop_i,
    output logic [$clog2(IBUF_DEPTH):0]  count_o,
    output logic                         valid_o,
    output logic [ADDR_WIDTH-1:0]        head_pc_o,
    output logic [DATA_WIDTH-1:0]        head_data_o
);

    localparam int PTR_W = $clog2(IBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] data_mem [IBUF_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [IBUF_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            data_mem[wr_ptr_q] <= push_data_i;
            pc_mem[wr_ptr_q]   <= push_pc_i;
        end
    end

    assign count_o     = count_q;
    assign valid_o     = (count_q != '0);
    assign head_pc_o   = valid_o ? pc_mem[rd_ptr_q]   : '0;
    assign head_data_o = valid_o ? data_mem[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Multi-cycle instruction fetch front end with boot-pointer load,
//               show-ahead instruction buffer and redirect/flush handling.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 'h0000_0FFC,
    parameter int                    IBUF_DEPTH   = 2,
    parameter int                    PC_INC       = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_o,
    output logic [2:0]            mem_size_o,
    input  logic                  mem_rdy_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                  ir_ld_i,
    output logic                  ir_valid_o,
    output logic [DATA_WIDTH-1:0] ir_o,
    output logic [ADDR_WIDTH-1:0] ir_pc_o,
    output logic                  booted_o,
    output logic                  fault_o
);

    localparam int                    CNT_W     = $clog2(IBUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0]      C_DEPTH   = CNT_W'(IBUF_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] C_PC_STEP = ADDR_WIDTH'(PC_INC);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  booted_q, booted_d;
    logic                  fault_q, fault_d;
    logic                  stale_q, stale_d;

    logic                  redirect_ok;
    logic                  buf_push;
    logic                  buf_pop;
    logic                  buf_valid;
    logic [CNT_W-1:0]      buf_count;
    logic [ADDR_WIDTH-1:0] buf_head_pc;
    logic [DATA_WIDTH-1:0] buf_head_data;

    assign redirect_ok = redirect_i && booted_q && (state_q != S_FAULT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        booted_d   = booted_q;
        fault_d    = fault_q;
        stale_d    = stale_q;
        buf_push   = 1'b0;

        case (state_q)
            S_BOOT_REQ: begin
                state_d    = S_BOOT_WAIT;
                mem_rd_d   = 1'b1;
                mem_addr_d = RESET_VECTOR;
            end
            S_BOOT_WAIT: begin
                if (mem_rdy_i) begin
                    pc_d     = ADDR_WIDTH'(mem_data_i);
                    booted_d = 1'b1;
                    mem_rd_d = 1'b0;
                    if (is_word_aligned(mem_data_i[1:0])) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                // Issuing only below full reserves the slot for the returning word.
                if (!redirect_ok && (buf_count < C_DEPTH)) begin
                    state_d    = S_WAIT;
                    mem_addr_d = pc_q;
                    mem_rd_d   = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_rdy_i) begin
                    state_d  = S_FETCH;
                    mem_rd_d = 1'b0;
                    stale_d  = 1'b0;
                    // A stale word belongs to the pre-redirect stream: drop it and keep pc.
                    if (!stale_q && !redirect_ok) begin
                        buf_push = 1'b1;
                        pc_d     = pc_q + C_PC_STEP;
                    end
                end
            end
            S_FAULT: begin
                mem_rd_d = 1'b0;
                fault_d  = 1'b1;
            end
            default: begin
                state_d  = S_FAULT;
                mem_rd_d = 1'b0;
                fault_d  = 1'b1;
            end
        endcase

        if (redirect_ok) begin
            pc_d = redirect_pc_i;
            if ((state_q == S_WAIT) && !mem_rdy_i) begin
                stale_d = 1'b1;
            end
            if (!is_word_aligned(redirect_pc_i[1:0])) begin
                state_d  = S_FAULT;
                fault_d  = 1'b1;
                mem_rd_d = 1'b0;
                stale_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_BOOT_REQ;
            pc_q       <= '0;
            mem_addr_q <= RESET_VECTOR;
            mem_rd_q   <= 1'b0;
            booted_q   <= 1'b0;
            fault_q    <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            booted_q   <= booted_d;
            fault_q    <= fault_d;
            stale_q    <= stale_d;
        end
    end

    assign buf_pop = ir_ld_i && ir_valid_o;

    fetch_ibuf #(
        .IBUF_DEPTH (IBUF_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ibuf (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (redirect_ok),
        .push_i      (buf_push),
        .push_pc_i   (mem_addr_q),
        .push_data_i (mem_data_i),
        .pop_i       (buf_pop),
        .count_o     (buf_count),
        .valid_o     (buf_valid),
        .head_pc_o   (buf_head_pc),
        .head_data_o (buf_head_data)
    );

    assign mem_addr_o = mem_addr_q;
    assign mem_rd_o   = mem_rd_q;
    assign mem_size_o = MEM_SIZE_WORD;
    assign ir_valid_o = buf_valid && !fault_q;
    assign ir_o       = ir_valid_o ? buf_head_data : '0;
    assign ir_pc_o    = ir_valid_o ? buf_head_pc   : '0;
    assign booted_o   = booted_q;
    assign fault_o    = fault_q;

endmodule
`default_nettype wire
